fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. It holds the program counter, drives the instruction-memory address, and registers the fetched word for decode. It also forms the branch/jump target from the sign-extended immediate (`ImmOp`) returned by the decode-side sign-extend unit, applies the redirect, and honours hazard-unit stall and flush.

---
 rtl/fetch_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and registers the fetched
// word for decode. Redirects come from execute. Stall and flush come from the
// hazard unit.
module fetch_stage #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  PCSrc,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic [DATA_WIDTH-1:0] InstrRD,
  output logic [DATA_WIDTH-1:0] InstrAddr,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic                  MisalignErr
);

  logic [DATA_WIDTH-1:0] r_pcF;
  logic [DATA_WIDTH-1:0] r_instrD;
  logic [DATA_WIDTH-1:0] r_pcD;
  logic [DATA_WIDTH-1:0] r_pcPlus4D;
  logic                  r_validD;
  logic                  r_misalignErr;

  logic [DATA_WIDTH-1:0] w_pcPlus4;
  logic [DATA_WIDTH-1:0] w_pcTarget;
  logic [DATA_WIDTH-1:0] w_alignedTarget;
  logic                  w_targetMisaligned;

  // The immediate arrives in imm[12:1] form, so it is doubled before the add.
  // Both sums simply wrap; a redirect target that is not word-aligned is
  // forced down to the word boundary and reported for one cycle.
  assign w_pcPlus4          = r_pcF + DATA_WIDTH'(4);
  assign w_pcTarget         = PCE + (ImmOp << 1);
  assign w_targetMisaligned = |w_pcTarget[1:0];
  assign w_alignedTarget    = {w_pcTarget[DATA_WIDTH-1:2], 2'b00};

  // Program counter: reset, then redirect (which beats stall), then hold, then +4.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcF <= RESET_PC;
    end else if (PCSrc) begin
      r_pcF <= w_alignedTarget;
    end else if (!Stall) begin
      r_pcF <= w_pcPlus4;
    end
  end

  // IF/ID register: a redirect or flush discards the wrong-path fetch as a bubble.
  always_ff @(posedge clk) begin
    if (rst || Flush || PCSrc) begin
      r_instrD   <= NOP_INSTR;
      r_pcD      <= '0;
      r_pcPlus4D <= '0;
      r_validD   <= 1'b0;
    end else if (!Stall) begin
      r_instrD   <= InstrRD;
      r_pcD      <= r_pcF;
      r_pcPlus4D <= w_pcPlus4;
      r_validD   <= 1'b1;
    end
  end

  // Misalignment flag pulses for exactly the cycle after a misaligned redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalignErr <= 1'b0;
    end else begin
      r_misalignErr <= PCSrc && w_targetMisaligned;
    end
  end

  assign InstrAddr   = r_pcF;
  assign InstrD      = r_instrD;
  assign PCD         = r_pcD;
  assign PCPlus4D    = r_pcPlus4D;
  assign ValidD      = r_validD;
  assign MisalignErr = r_misalignErr;

endmodule
